multicycle_mux_controller: RTL and testbench

//  Moore FSM sequencing the multi-cycle MIPS datapath: drives every datapath mux select
//  (ALUSrcB/PCSource 2-bit 2:1 and 4:1 muxes, ALUSrcA, IorD, RegDst, MemtoReg) and all write enables.

---
 rtl/multicycle_mux_controller.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_mux_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mux_controller.sv
// multicycle_mux_controller: Moore FSM sequencing the multi-cycle MIPS datapath.
// Drives every datapath mux select and write enable from the current state,
// waits on MemReady in FETCH/MEMRD/MEMWR, flags unsupported opcodes and
// counts retired instructions.
// Optional feature: define MUXCTL_ADDI_EN to build the ADDIEX/ADDIWB path;
// without it OP_ADDI decodes as an illegal opcode.
module multicycle_mux_controller #(
   parameter logic [5:0]  OP_RTYPE = 6'h00,
   parameter logic [5:0]  OP_LW    = 6'h23,
   parameter logic [5:0]  OP_SW    = 6'h2B,
   parameter logic [5:0]  OP_BEQ   = 6'h04,
   parameter logic [5:0]  OP_J     = 6'h02,
   parameter logic [5:0]  OP_ADDI  = 6'h08,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic [3:0]       State,
   output logic             Illegal,
   output logic [CNT_W-1:0] RetireCnt
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   state_t state;

   // Zero is consumed by the datapath's PC-load gate, not by the sequencer.
   logic zero_unused;
   assign zero_unused = Zero;

   assign State = state;

   // State sequencing, illegal-opcode pulse and retire counter.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= FETCH;
         Illegal   <= 1'b0;
         RetireCnt <= '0;
      end else begin
         Illegal <= 1'b0;
         case (state)
            FETCH: begin
               if (MemReady) state <= DECODE;
            end
            DECODE: begin
               if (Opcode == OP_LW || Opcode == OP_SW) begin
                  state <= MEMADR;
               end else if (Opcode == OP_RTYPE) begin
                  state <= EXEC;
               end else if (Opcode == OP_BEQ) begin
                  state <= BRANCH;
               end else if (Opcode == OP_J) begin
                  state <= JUMP;
`ifdef MUXCTL_ADDI_EN
               end else if (Opcode == OP_ADDI) begin
                  state <= ADDIEX;
`endif
               end else begin
                  state   <= FETCH;
                  Illegal <= 1'b1;
               end
            end
            MEMADR: begin
               state <= (Opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
               if (MemReady) state <= MEMWB;
            end
            MEMWB: begin
               state     <= FETCH;
               RetireCnt <= RetireCnt + CNT_W'(1);
            end
            MEMWR: begin
               if (MemReady) begin
                  state     <= FETCH;
                  RetireCnt <= RetireCnt + CNT_W'(1);
               end
            end
            EXEC: begin
               state <= RWB;
            end
            RWB: begin
               state     <= FETCH;
               RetireCnt <= RetireCnt + CNT_W'(1);
            end
            BRANCH: begin
               state     <= FETCH;
               RetireCnt <= RetireCnt + CNT_W'(1);
            end
            JUMP: begin
               state     <= FETCH;
               RetireCnt <= RetireCnt + CNT_W'(1);
            end
`ifdef MUXCTL_ADDI_EN
            ADDIEX: begin
               state <= ADDIWB;
            end
            ADDIWB: begin
               state     <= FETCH;
               RetireCnt <= RetireCnt + CNT_W'(1);
            end
`endif
            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

   // Control decode from state; everything held low while Rst is asserted.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'd0;
      PCSource    = 2'd0;
      ALUOp       = 2'd0;
      if (!Rst) begin
         case (state)
            FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'd1;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            DECODE: begin
               ALUSrcB = 2'd3;
            end
            MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'd2;
            end
            RWB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'd1;
               PCWriteCond = 1'b1;
               PCSource    = 2'd1;
            end
            JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'd2;
            end
`ifdef MUXCTL_ADDI_EN
            ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'd2;
            end
            ADDIWB: begin
               RegWrite = 1'b1;
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_mux_controller.sv
// Directed bench for multicycle_mux_controller with a queue-based scoreboard.
// A second instance with a 2-bit counter exercises RetireCnt wrap-around.
module tb_multicycle_mux_controller;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [5:0] Opcode;
   logic       Zero;
   logic       MemReady;

   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic RegWrite, RegDst, ALUSrcA, Illegal;
   logic [1:0]  ALUSrcB, PCSource, ALUOp;
   logic [3:0]  State;
   logic [31:0] RetireCnt;

   logic w_PCWrite, w_PCWriteCond, w_IorD, w_MemRead, w_MemWrite, w_MemtoReg, w_IRWrite;
   logic w_RegWrite, w_RegDst, w_ALUSrcA, w_Illegal;
   logic [1:0] w_ALUSrcB, w_PCSource, w_ALUOp;
   logic [3:0] w_State;
   logic [1:0] w_RetireCnt;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int unsigned exp_cnt = 0;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   exp_t sbq[$];

   logic [15:0] obs_ctl;
   assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp};

   multicycle_mux_controller #(.CNT_W(32)) dut (
      .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp), .State(State), .Illegal(Illegal), .RetireCnt(RetireCnt)
   );

   multicycle_mux_controller #(.CNT_W(2)) dut_w (
      .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .MemRead(w_MemRead),
      .MemWrite(w_MemWrite), .MemtoReg(w_MemtoReg), .IRWrite(w_IRWrite), .RegWrite(w_RegWrite),
      .RegDst(w_RegDst), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .PCSource(w_PCSource),
      .ALUOp(w_ALUOp), .State(w_State), .Illegal(w_Illegal), .RetireCnt(w_RetireCnt)
   );

   always #5 Clk = ~Clk;

   // Expected controls per state, written from the state table:
   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,PCSource,ALUOp}
   function automatic logic [15:0] exp_ctl(input int unsigned st, input logic mr, input logic rst);
      logic [15:0] v;
      v = '0;
      if (!rst) begin
         case (st)
            0:  v = {1'b0, 6'b000100, 1'b0, 3'b000, 2'd1, 2'd0, 2'd0} | {mr, 5'b0, mr, 9'b0};
            1:  v = {10'b0, 2'd3, 2'd0, 2'd0};
            2:  v = {9'b0, 1'b1, 2'd2, 2'd0, 2'd0};
            3:  v = {2'b00, 1'b1, 1'b1, 6'b0, 6'b0};
            4:  v = {5'b0, 1'b1, 1'b0, 1'b1, 2'b00, 6'b0};
            5:  v = {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 6'b0};
            6:  v = {9'b0, 1'b1, 2'd0, 2'd0, 2'd2};
            7:  v = {7'b0, 1'b1, 1'b1, 1'b0, 6'b0};
            8:  v = {1'b0, 1'b1, 7'b0, 1'b1, 2'd0, 2'd1, 2'd1};
            9:  v = {1'b1, 9'b0, 2'd0, 2'd2, 2'd0};
            10: v = {9'b0, 1'b1, 2'd2, 2'd0, 2'd0};
            11: v = {7'b0, 1'b1, 2'b00, 6'b0};
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   // One clock: enqueue expectation, compare at the falling edge, advance past next rising edge.
   task automatic cyc(input int unsigned st, input logic ill);
      exp_t e;
      exp_t got;
      e.st  = st[3:0];
      e.ctl = exp_ctl(st, MemReady, Rst);
      e.ill = ill;
      e.cnt = exp_cnt;
      sbq.push_back(e);
      @(negedge Clk);
      got = sbq.pop_front();
      n_vec++;
      assert (State === got.st) else begin
         n_bad++;
         $error("FAIL state: observed %0d expected %0d", State, got.st);
      end
      n_vec++;
      assert (obs_ctl === got.ctl) else begin
         n_bad++;
         $error("FAIL ctl(st%0d): observed %b expected %b", got.st, obs_ctl, got.ctl);
      end
      n_vec++;
      assert (Illegal === got.ill) else begin
         n_bad++;
         $error("FAIL illegal(st%0d): observed %b expected %b", got.st, Illegal, got.ill);
      end
      n_vec++;
      assert (RetireCnt === got.cnt) else begin
         n_bad++;
         $error("FAIL retirecnt: observed %0d expected %0d", RetireCnt, got.cnt);
      end
      n_vec++;
      assert (w_RetireCnt === got.cnt[1:0]) else begin
         n_bad++;
         $error("FAIL retirecnt_w2: observed %0d expected %0d", w_RetireCnt, got.cnt[1:0]);
      end
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Rst = 1'b1; MemReady = 1'b1; Opcode = 6'h00; Zero = 1'b0;
      // reset state
      cyc(0, 1'b0);
      Rst = 1'b0;

      // LW aborted by reset while waiting in MEMRD
      Opcode = 6'h23;
      cyc(0, 1'b0); cyc(1, 1'b0); cyc(2, 1'b0);
      MemReady = 1'b0;
      cyc(3, 1'b0);
      Rst = 1'b1;
      cyc(0, 1'b0);
      Rst = 1'b0; MemReady = 1'b1;

      // LW, MemReady=1 throughout
      cyc(0, 1'b0); cyc(1, 1'b0); cyc(2, 1'b0); cyc(3, 1'b0); cyc(4, 1'b0);
      exp_cnt++;

      // SW with one wait cycle in MEMWR; MemReady low in DECODE/MEMADR is ignored
      Opcode = 6'h2B;
      cyc(0, 1'b0);
      MemReady = 1'b0;
      cyc(1, 1'b0); cyc(2, 1'b0); cyc(5, 1'b0);
      MemReady = 1'b1;
      cyc(5, 1'b0);
      exp_cnt++;

      // R-type with FETCH stalled two cycles
      Opcode = 6'h00; MemReady = 1'b0;
      cyc(0, 1'b0); cyc(0, 1'b0);
      MemReady = 1'b1;
      cyc(0, 1'b0); cyc(1, 1'b0); cyc(6, 1'b0); cyc(7, 1'b0);
      exp_cnt++;

      // BEQ taken then not taken
      Opcode = 6'h04; Zero = 1'b1;
      cyc(0, 1'b0); cyc(1, 1'b0); cyc(8, 1'b0);
      exp_cnt++;
      Zero = 1'b0;
      cyc(0, 1'b0); cyc(1, 1'b0); cyc(8, 1'b0);
      exp_cnt++;

      // Unsupported opcode: back to FETCH with a one-cycle Illegal pulse, then a J
      Opcode = 6'h3F;
      cyc(0, 1'b0); cyc(1, 1'b0);
      Opcode = 6'h02;
      cyc(0, 1'b1); cyc(1, 1'b0); cyc(9, 1'b0);
      exp_cnt++;

      // ADDI
      Opcode = 6'h08;
      cyc(0, 1'b0); cyc(1, 1'b0);
`ifdef MUXCTL_ADDI_EN
      cyc(10, 1'b0); cyc(11, 1'b0);
      exp_cnt++;
      cyc(0, 1'b0);
`else
      cyc(0, 1'b1);
`endif
      Opcode = 6'h02;
      cyc(1, 1'b0);
      cyc(9, 1'b0);
      exp_cnt++;
      cyc(0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
